// File: rtl/brick_draw_if.sv
// Brick channel bundle between the frame controller (master) and brick_draw (slave).
// go is a one-cycle request with no ready: it is taken only while the block is idle
// (busy low) and dropped otherwise. writeEn is a pixel valid strobe with no backpressure.
interface brick_draw_if #(
  parameter int N = 32
);
  logic         go;
  logic [N-1:0] alive;
  logic [9:0]   x;
  logic [9:0]   y;
  logic [2:0]   color;
  logic         writeEn;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  modport master (
    output go, alive,
    input  x, y, color, writeEn, busy, done, state
  );

  modport slave (
    input  go, alive,
    output x, y, color, writeEn, busy, done, state
  );
endinterface

// File: rtl/brick_draw.sv
// Brick field pixel generator: walks the live bricks latched at go in row-major order,
// one pixel per cycle, then pulses done.
module brick_draw #(
  parameter int COLS     = 8,
  parameter int ROWS     = 4,
  parameter int BRICK_W  = 16,
  parameter int BRICK_H  = 4,
  parameter int GAP      = 2,
  parameter int ORIGIN_X = 8,
  parameter int ORIGIN_Y = 8
) (
  input  logic        clk,
  input  logic        reset,
  brick_draw_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PX_W  = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int PY_W  = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(BRICK_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(BRICK_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PX_W-1:0]  px_q, px_d;
  logic [PY_W-1:0]  py_q, py_d;
  logic [N-1:0]     alive_q, alive_d;

  int col_w;
  int row_w;

  assign col_w = int'(idx_q) % COLS;
  assign row_w = int'(idx_q) / COLS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      alive_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      alive_q <= alive_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    alive_d = alive_q;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          alive_d = bus.alive;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (alive_q[idx_q]) begin
          px_d    = '0;
          py_d    = '0;
          state_d = DRAW;
        end else if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAW: begin
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (py_q == PY_LAST) begin
            // Last pixel of this brick: either the frame ends or scanning resumes.
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = SCAN;
            end
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel coordinates are forced to zero outside DRAW so nothing undefined leaks out.
  always_comb begin
    bus.x       = '0;
    bus.y       = '0;
    bus.color   = '0;
    bus.writeEn = 1'b0;
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.state   = state_q;
    if (state_q == DRAW) begin
      bus.writeEn = 1'b1;
      bus.x       = 10'(ORIGIN_X + col_w * (BRICK_W + GAP) + int'(px_q));
      bus.y       = 10'(ORIGIN_Y + row_w * (BRICK_H + GAP) + int'(py_q));
      bus.color   = 3'((row_w % 7) + 1);
    end
  end
endmodule

// File: tb/tb_brick_draw.sv
// Directed bench for brick_draw: full frames against a pixel scoreboard, plus
// ignored-go, dead-field and mid-frame reset cases.
module tb_brick_draw;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [22:0] exp_q[$];

  brick_draw_if #(.N(32)) bus ();

  brick_draw dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected raster for one frame: brick i sits at (8 + col*18, 8 + row*6).
  task automatic build_expect(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (a[i]) begin
        for (int py = 0; py < 4; py++) begin
          for (int px = 0; px < 16; px++) begin
            exp_q.push_back({10'(8 + (i % 8) * 18 + px), 10'(8 + (i / 8) * 6 + py), 3'((i / 8) % 7 + 1)});
          end
        end
      end
    end
  endtask

  // mode 1: re-pulse go and flip alive mid-frame; mode 2: raise go during the DONE cycle.
  task automatic run_frame(input string tag, input logic [31:0] a, input int exp_writes,
                           input int exp_done_cyc, input logic [22:0] exp_first,
                           input logic [22:0] exp_last, input int mode);
    int cyc;
    int writes;
    int done_cyc;
    logic [22:0] first_pix;
    logic [22:0] last_pix;
    logic [22:0] got_pix;
    build_expect(a);
    writes    = 0;
    done_cyc  = -1;
    first_pix = '0;
    last_pix  = '0;
    @(negedge clk);
    bus.alive = a;
    bus.go    = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    cyc = 0;
    while (done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.writeEn) begin
        got_pix = {bus.x, bus.y, bus.color};
        if (writes == 0) first_pix = got_pix;
        last_pix = got_pix;
        writes++;
        if (exp_q.size() == 0) check({tag, "_extra_pixel"}, 32'(got_pix), 32'd0);
        else check({tag, "_pixel"}, 32'(got_pix), 32'(exp_q.pop_front()));
      end
      if (bus.done) done_cyc = cyc;
      if (mode == 1 && cyc == 5) begin
        bus.go    = 1'b1;
        bus.alive = 32'hFFFF_FFFF;
      end
      if (mode == 1 && cyc == 6) bus.go = 1'b0;
      if (mode == 2 && bus.done) bus.go = 1'b1;
      if (done_cyc < 0 && cyc >= 3000) begin
        check({tag, "_timeout"}, 32'(cyc), 32'(exp_done_cyc));
        done_cyc = cyc;
      end
    end
    check({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check({tag, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    if (exp_writes > 0) begin
      check({tag, "_first_pixel"}, 32'(first_pix), 32'(exp_first));
      check({tag, "_last_pixel"}, 32'(last_pix), 32'(exp_last));
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_state"}, 32'(bus.state), 32'd0);
    bus.go = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      check({tag, "_go_in_done_ignored"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int done_seen;
    n_checks  = 0;
    n_fail    = 0;
    bus.go    = 1'b0;
    bus.alive = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_color", 32'(bus.color), 32'd0);
    check("rst_writeEn", 32'(bus.writeEn), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full field: first (8,8) colour 1, last (149,29) colour 4.
    run_frame("all", 32'hFFFF_FFFF, 2048, 2081, {10'd8, 10'd8, 3'd1}, {10'd149, 10'd29, 3'd4}, 0);
    run_frame("bit0", 32'h0000_0001, 64, 97, {10'd8, 10'd8, 3'd1}, {10'd23, 10'd11, 3'd1}, 0);
    run_frame("bit9", 32'h0000_0200, 64, 97, {10'd26, 10'd14, 3'd2}, {10'd41, 10'd17, 3'd2}, 0);
    run_frame("none", 32'h0000_0000, 0, 33, '0, '0, 2);
    run_frame("bit0_disturbed", 32'h0000_0001, 64, 97, {10'd8, 10'd8, 3'd1}, {10'd23, 10'd11, 3'd1}, 1);
    run_frame("all_after", 32'hFFFF_FFFF, 2048, 2081, {10'd8, 10'd8, 3'd1}, {10'd149, 10'd29, 3'd4}, 0);

    // Mid-frame reset at pixel 10 of brick 0 (cycle 12: cycle 1 scan, cycles 2.. draw).
    @(negedge clk);
    bus.alive = 32'h0000_0001;
    bus.go    = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_pre_x", 32'(bus.x), 32'd18);
    check("rst_mid_pre_we", 32'(bus.writeEn), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(bus.writeEn), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_x", 32'(bus.x), 32'd0);
    check("rst_mid_y", 32'(bus.y), 32'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done || bus.writeEn) done_seen++;
    end
    check("rst_mid_no_done", 32'(done_seen), 32'd0);
    run_frame("after_reset", 32'h0000_0001, 64, 97, {10'd8, 10'd8, 3'd1}, {10'd23, 10'd11, 3'd1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
